// File: rtl/symbol_aligner.sv
// symbol_aligner
// Receive-side 8b/10b symbol alignment. Watches the shifter's 10-bit sliding
// window for K28.5 (either disparity), acquires symbol lock with a small FSM
// and emits one aligned symbol every 10 bit clocks while locked.
//
// Ports:
//   CRC_CKL      in   1  recovered bit clock, rising edge
//   RESET_L      in   1  synchronous active-low reset
//   data_in      in  10  sliding window, bit 9 newest, bit 0 oldest
//   symbol_out   out 10  aligned symbol, held between strobes
//   symbol_valid out  1  one-cycle strobe, symbol_out is new
//   comma_out    out  1  symbol_out is a comma (qualified by symbol_valid)
//   LOCK         out  1  FSM is in LOCKED
//   align_err    out  1  pulse per misaligned comma while LOCKED
module symbol_aligner #(
    parameter logic [9:0] COMMA_NEG = 10'h17C,
    parameter logic [9:0] COMMA_POS = 10'h283,
    parameter int         LOCK_CNT  = 3,
    parameter int         LOSS_CNT  = 4
) (
    input  logic       CRC_CKL,
    input  logic       RESET_L,
    input  logic [9:0] data_in,
    output logic [9:0] symbol_out,
    output logic       symbol_valid,
    output logic       comma_out,
    output logic       LOCK,
    output logic       align_err
);

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_ALIGNING = 2'd1,
        ST_LOCKED   = 2'd2
    } state_t;

    localparam logic [3:0] LP_LOCK     = 4'(LOCK_CNT);
    localparam logic [3:0] LP_LOSS     = 4'(LOSS_CNT);
    // A single comma is enough to lock straight from UNLOCKED
    localparam logic       LP_LOCK_ONE = (LOCK_CNT == 1);

    state_t     r_state;
    state_t     w_next_state;
    logic [3:0] r_phase;
    logic [3:0] r_comma_cnt;
    logic [3:0] r_err_cnt;
    logic [9:0] r_symbol;
    logic       r_comma;
    logic       r_valid;
    logic       r_lock;
    logic       r_align_err;

    logic       w_is_comma;
    logic       w_boundary;
    logic [3:0] w_comma_inc;
    logic [3:0] w_err_inc;
    logic       w_lock_reached;
    logic       w_loss_reached;
    logic       w_realign;
    logic       w_count;
    logic       w_emit;
    logic       w_err;
    logic       w_clear_err;

    assign w_is_comma = (data_in == COMMA_NEG) || (data_in == COMMA_POS);
    // Re-alignment loads phase with 1, so phase 0 falls exactly 10 cycles later
    assign w_boundary = (r_phase == 4'd0);

    // Saturating increments: counters stick at 15 instead of wrapping
    assign w_comma_inc    = (r_comma_cnt == 4'd15) ? 4'd15 : r_comma_cnt + 4'd1;
    assign w_err_inc      = (r_err_cnt == 4'd15) ? 4'd15 : r_err_cnt + 4'd1;
    assign w_lock_reached = (w_comma_inc >= LP_LOCK);
    assign w_loss_reached = (w_err_inc >= LP_LOSS);

    // State register
    always_ff @(posedge CRC_CKL) begin
        if (!RESET_L) begin
            r_state <= ST_UNLOCKED;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_UNLOCKED: begin
                if (w_is_comma) begin
                    w_next_state = LP_LOCK_ONE ? ST_LOCKED : ST_ALIGNING;
                end else begin
                    w_next_state = ST_UNLOCKED;
                end
            end
            ST_ALIGNING: begin
                if (w_is_comma && w_boundary && w_lock_reached) begin
                    w_next_state = ST_LOCKED;
                end else begin
                    w_next_state = ST_ALIGNING;
                end
            end
            ST_LOCKED: begin
                if (w_is_comma && !w_boundary && w_loss_reached) begin
                    w_next_state = ST_UNLOCKED;
                end else begin
                    w_next_state = ST_LOCKED;
                end
            end
            default: w_next_state = ST_UNLOCKED;
        endcase
    end

    // Per-state actions: re-alignment, counting, symbol emission, errors
    always_comb begin
        w_realign   = 1'b0;
        w_count     = 1'b0;
        w_emit      = 1'b0;
        w_err       = 1'b0;
        w_clear_err = 1'b0;
        case (r_state)
            ST_UNLOCKED: begin
                if (w_is_comma) begin
                    w_realign = 1'b1;
                    w_emit    = LP_LOCK_ONE;
                end else begin
                    w_realign = 1'b0;
                end
            end
            ST_ALIGNING: begin
                if (w_is_comma && w_boundary) begin
                    w_count = 1'b1;
                    // The comma that completes lock is itself emitted
                    w_emit  = w_lock_reached;
                end else if (w_is_comma) begin
                    w_realign = 1'b1;
                end else begin
                    w_count = 1'b0;
                end
            end
            ST_LOCKED: begin
                if (w_boundary) begin
                    w_emit      = 1'b1;
                    w_clear_err = w_is_comma;
                end else if (w_is_comma) begin
                    w_err = 1'b1;
                end else begin
                    w_emit = 1'b0;
                end
            end
            default: begin
                w_emit = 1'b0;
            end
        endcase
    end

    // Phase, counters and registered outputs
    always_ff @(posedge CRC_CKL) begin
        if (!RESET_L) begin
            r_phase     <= 4'd0;
            r_comma_cnt <= 4'd0;
            r_err_cnt   <= 4'd0;
            r_symbol    <= 10'd0;
            r_comma     <= 1'b0;
            r_valid     <= 1'b0;
            r_lock      <= 1'b0;
            r_align_err <= 1'b0;
        end else begin
            if (w_realign) begin
                r_phase <= 4'd1;
            end else if (r_phase == 4'd9) begin
                r_phase <= 4'd0;
            end else begin
                r_phase <= r_phase + 4'd1;
            end

            if (w_realign) begin
                r_comma_cnt <= 4'd1;
            end else if (w_count) begin
                r_comma_cnt <= w_comma_inc;
            end else begin
                r_comma_cnt <= r_comma_cnt;
            end

            // Error count only lives while locked; it restarts on every entry
            if (r_state != ST_LOCKED) begin
                r_err_cnt <= 4'd0;
            end else if (w_clear_err) begin
                r_err_cnt <= 4'd0;
            end else if (w_err) begin
                r_err_cnt <= w_loss_reached ? 4'd0 : w_err_inc;
            end else begin
                r_err_cnt <= r_err_cnt;
            end

            if (w_emit) begin
                r_symbol <= data_in;
                r_comma  <= w_is_comma;
            end else begin
                r_symbol <= r_symbol;
                r_comma  <= r_comma;
            end

            r_valid     <= w_emit;
            r_align_err <= w_err;
            r_lock      <= (w_next_state == ST_LOCKED);
        end
    end

    assign symbol_out   = r_symbol;
    assign symbol_valid = r_valid;
    assign comma_out    = r_comma;
    assign LOCK         = r_lock;
    assign align_err    = r_align_err;

endmodule

// File: tb/tb_symbol_aligner.sv
// Testbench for symbol_aligner: serializes bit streams into a sliding window,
// predicts outputs with a cycle-index reference model and checks them through
// a scoreboard monitor.
module tb_symbol_aligner;

    localparam int LOCK_CNT = 3;
    localparam int LOSS_CNT = 4;

    logic       CRC_CKL = 1'b0;
    logic       RESET_L = 1'b0;
    logic [9:0] data_in = 10'd0;
    logic [9:0] symbol_out;
    logic       symbol_valid;
    logic       comma_out;
    logic       LOCK;
    logic       align_err;

    symbol_aligner #(
        .COMMA_NEG(10'h17C),
        .COMMA_POS(10'h283),
        .LOCK_CNT (LOCK_CNT),
        .LOSS_CNT (LOSS_CNT)
    ) dut (
        .CRC_CKL     (CRC_CKL),
        .RESET_L     (RESET_L),
        .data_in     (data_in),
        .symbol_out  (symbol_out),
        .symbol_valid(symbol_valid),
        .comma_out   (comma_out),
        .LOCK        (LOCK),
        .align_err   (align_err)
    );

    always #5 CRC_CKL = ~CRC_CKL;

    typedef struct {
        logic       lock;
        logic       err;
        logic       valid;
        logic [9:0] sym;
        logic       com;
    } st_t;

    st_t         st_q[$];
    logic [10:0] sym_q[$];

    int errors = 0;
    int checks = 0;
    int obs_err = 0;

    // Reference model state: mode 0=unlocked 1=aligning 2=locked
    int         m_mode = 0;
    int         m_cnt = 0;
    int         m_err = 0;
    int         m_t = 0;
    int         m_anchor = 0;
    logic [9:0] m_sym = 10'd0;
    logic       m_com = 1'b0;

    logic [9:0] win = 10'd0;
    logic       rd = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Boundaries are every 10th cycle counted from the last alignment cycle
    task automatic model_step(input logic rst_l, input logic [9:0] w);
        st_t  e;
        logic c;
        logic b;
        m_t++;
        e.valid = 1'b0;
        e.err   = 1'b0;
        if (!rst_l) begin
            m_mode = 0;
            m_cnt  = 0;
            m_err  = 0;
            m_sym  = 10'd0;
            m_com  = 1'b0;
        end else begin
            c = (w == 10'h17C) || (w == 10'h283);
            b = (m_mode != 0) && (m_t > m_anchor) && (((m_t - m_anchor) % 10) == 0);
            if (m_mode == 0) begin
                if (c) begin
                    m_anchor = m_t;
                    m_cnt    = 1;
                    if (m_cnt >= LOCK_CNT) begin
                        m_mode  = 2;
                        e.valid = 1'b1;
                    end else begin
                        m_mode = 1;
                    end
                end
            end else if (m_mode == 1) begin
                if (c && b) begin
                    m_cnt++;
                    if (m_cnt >= LOCK_CNT) begin
                        m_mode  = 2;
                        e.valid = 1'b1;
                    end
                end else if (c) begin
                    m_anchor = m_t;
                    m_cnt    = 1;
                end
            end else begin
                if (b) begin
                    e.valid = 1'b1;
                    if (c) m_err = 0;
                end else if (c) begin
                    e.err = 1'b1;
                    m_err++;
                    if (m_err >= LOSS_CNT) begin
                        m_mode = 0;
                        m_err  = 0;
                    end
                end
            end
            if (e.valid) begin
                m_sym = w;
                m_com = c;
                sym_q.push_back({c, w});
            end
        end
        e.lock = (m_mode == 2);
        e.sym  = m_sym;
        e.com  = m_com;
        st_q.push_back(e);
    endtask

    task automatic drive(input logic rst_l, input logic [9:0] w);
        @(negedge CRC_CKL);
        RESET_L = rst_l;
        data_in = w;
        model_step(rst_l, w);
    endtask

    task automatic send_bit(input logic b);
        win = {b, win[9:1]};
        drive(1'b1, win);
    endtask

    task automatic send_sym(input logic [9:0] s);
        for (int i = 0; i < 10; i++) send_bit(s[i]);
    endtask

    task automatic send_comma();
        send_sym(rd ? 10'h283 : 10'h17C);
        rd = ~rd;
    endtask

    // Alternating filler bits: never five equal bits, so never part of a comma
    task automatic send_filler(input int n);
        for (int i = 0; i < n; i++) send_bit(i[0]);
    endtask

    task automatic settle();
        @(posedge CRC_CKL);
        #2;
    endtask

    st_t         mon_e;
    logic [10:0] mon_s;

    // Scoreboard monitor: per-cycle status plus symbol queue on each strobe
    always @(posedge CRC_CKL) begin
        #1;
        if (st_q.size() > 0) begin
            mon_e = st_q.pop_front();
            chk("lock", 32'(LOCK), 32'(mon_e.lock));
            chk("align_err", 32'(align_err), 32'(mon_e.err));
            chk("symbol_valid", 32'(symbol_valid), 32'(mon_e.valid));
            chk("symbol_out_held", 32'(symbol_out), 32'(mon_e.sym));
            chk("comma_out_held", 32'(comma_out), 32'(mon_e.com));
        end
        if (symbol_valid === 1'b1) begin
            if (sym_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_symbol: got %0h with no symbol expected", symbol_out);
            end else begin
                mon_s = sym_q.pop_front();
                chk("emit_symbol", 32'(symbol_out), 32'(mon_s[9:0]));
                chk("emit_comma", 32'(comma_out), 32'(mon_s[10]));
            end
        end
        if (align_err === 1'b1) obs_err++;
    end

    initial begin
        int base;
        int k;
        int n;

        // Reset held with a comma in the window
        win = 10'h17C;
        repeat (3) drive(1'b0, win);
        settle();
        chk("reset_lock", 32'(LOCK), 32'd0);
        chk("reset_symbol", 32'(symbol_out), 32'd0);
        chk("reset_valid", 32'(symbol_valid), 32'd0);

        // Acquisition at bit offset 3
        send_filler(3);
        repeat (3) send_comma();
        repeat (4) send_sym(10'h1AA);
        chk("acq_lock", 32'(LOCK), 32'd1);

        // Loss of lock: four commas shifted by 5 bits
        base = obs_err;
        send_filler(5);
        repeat (4) send_comma();
        repeat (3) send_sym(10'h1AA);
        chk("loss_err_pulses", 32'(obs_err - base), 32'd4);
        chk("loss_lock", 32'(LOCK), 32'd0);

        // Re-align during ALIGNING: two commas, then commas offset by 4
        repeat (2) send_comma();
        send_filler(4);
        repeat (2) send_comma();
        chk("realign_no_lock", 32'(LOCK), 32'd0);
        send_comma();
        repeat (2) send_sym(10'h1AA);
        chk("realign_lock", 32'(LOCK), 32'd1);

        // Error clear: 3 misaligned, 1 aligned, 3 misaligned
        base = obs_err;
        send_filler(5);
        repeat (3) send_comma();
        send_filler(5);
        send_comma();
        send_filler(5);
        repeat (3) send_comma();
        send_filler(5);
        repeat (3) send_sym(10'h1AA);
        chk("clear_err_pulses", 32'(obs_err - base), 32'd6);
        chk("clear_lock", 32'(LOCK), 32'd1);

        // Mid-lock reset, then fresh acquisition
        drive(1'b0, win);
        settle();
        chk("midrst_lock", 32'(LOCK), 32'd0);
        chk("midrst_valid", 32'(symbol_valid), 32'd0);
        repeat (2) send_comma();
        chk("midrst_relock_early", 32'(LOCK), 32'd0);
        send_comma();
        repeat (2) send_sym(10'h1AA);
        chk("midrst_relock", 32'(LOCK), 32'd1);

        // Randomized streams checked by the model
        for (int s = 0; s < 400; s++) begin
            k = $urandom_range(0, 31);
            if (k == 0) begin
                drive(1'b0, win);
            end else if (k <= 4) begin
                n = $urandom_range(1, 9);
                for (int i = 0; i < n; i++) send_bit(1'($urandom_range(0, 1)));
            end else if (k <= 20) begin
                send_comma();
            end else begin
                send_sym(10'($urandom));
            end
        end

        repeat (3) send_sym(10'h1AA);
        repeat (3) settle();
        chk("status_queue_drained", 32'(st_q.size()), 32'd0);
        chk("symbol_queue_drained", 32'(sym_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
